// File: rtl/w5300_bus_arbiter.sv
// Round-robin arbiter that multiplexes NUM_REQ register-access requesters onto a
// single W5300 bus engine, one access per grant, with a per-access timeout.
module w5300_bus_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter logic [15:0] TIMEOUT = 16'd64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*11-1:0]   req_addr,
    input  logic [NUM_REQ*16-1:0]   req_wr_data,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      req_op_state,
    output logic [15:0]             req_rd_data,
    output logic [10:0]             bus_addr,
    output logic [15:0]             bus_wr_data,
    output logic                    bus_start,
    input  logic                    bus_done,
    input  logic [15:0]             bus_rd_data,
    output logic                    timeout_err
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Direction code in bit 10: read = 0, write = 1.
    localparam logic        DIR_RD    = 1'b0;
    localparam logic [10:0] IDLE_ADDR = {DIR_RD, 10'h3fe};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_RELEASE
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       winner;
    logic [PW-1:0]       winner_inc;
    logic [PW-1:0]       pick_idx;
    logic [PW-1:0]       scan_idx;
    logic                pick_found;
    logic [NUM_REQ-1:0]  win_onehot;
    logic [15:0]         tmo_cnt;
    logic [15:0]         tmo_cnt_inc;
    logic                tmo_hit;
    logic                op_ok;
    logic [10:0]         addr_slot [NUM_REQ];
    logic [15:0]         data_slot [NUM_REQ];

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            addr_slot[i] = req_addr[11*i +: 11];
            data_slot[i] = req_wr_data[16*i +: 16];
        end
    end

    // First requesting index at or after rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_idx = PW'((32'(rr_ptr) + i) % NUM_REQ);
            if (!pick_found && req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            win_onehot[i] = (winner == PW'(i));
        end
    end

    assign winner_inc  = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    assign tmo_cnt_inc = tmo_cnt + 16'd1;
    assign tmo_hit     = (tmo_cnt_inc == TIMEOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        gnt          = '0;
        bus_start    = 1'b0;
        req_op_state = '0;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_nx = ST_START;
                end
            end
            ST_START: begin
                gnt       = win_onehot;
                bus_start = 1'b1;
                state_nx  = ST_WAIT;
            end
            ST_WAIT: begin
                gnt = win_onehot;
                if (bus_done || tmo_hit) begin
                    state_nx = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (op_ok) begin
                    req_op_state = win_onehot;
                end
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // bus_addr is parked on the idle pattern when leaving RELEASE so that it
    // already reads as idle throughout every IDLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            winner      <= '0;
            tmo_cnt     <= '0;
            op_ok       <= 1'b0;
            req_rd_data <= '0;
            bus_addr    <= IDLE_ADDR;
            bus_wr_data <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        winner      <= pick_idx;
                        bus_addr    <= addr_slot[pick_idx];
                        bus_wr_data <= data_slot[pick_idx];
                    end
                end
                ST_START: begin
                    tmo_cnt <= '0;
                    op_ok   <= 1'b0;
                end
                ST_WAIT: begin
                    tmo_cnt <= tmo_cnt_inc;
                    if (bus_done) begin
                        req_rd_data <= bus_rd_data;
                        op_ok       <= 1'b1;
                        rr_ptr      <= winner_inc;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        rr_ptr      <= winner_inc;
                    end
                end
                ST_RELEASE: begin
                    bus_addr    <= IDLE_ADDR;
                    bus_wr_data <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_w5300_bus_arbiter.sv
// Self-checking bench for w5300_bus_arbiter: a transaction-level model predicts
// every output per cycle; directed scenarios pin the model with literal values.
module tb_w5300_bus_arbiter;

    localparam int unsigned N  = 3;
    localparam logic [15:0] TO = 16'd8;
    localparam logic        WR = 1'b1;
    localparam logic        RD = 1'b0;
    localparam logic [10:0] DEF_ADDR = {RD, 10'h3fe};
    localparam int          BIG = 32'h7fffffff;

    logic                clk;
    logic                rst_n;
    logic [N-1:0]        req;
    logic [N*11-1:0]     req_addr;
    logic [N*16-1:0]     req_wr_data;
    logic [N-1:0]        gnt;
    logic [N-1:0]        req_op_state;
    logic [15:0]         req_rd_data;
    logic [10:0]         bus_addr;
    logic [15:0]         bus_wr_data;
    logic                bus_start;
    logic                bus_done;
    logic [15:0]         bus_rd_data;
    logic                timeout_err;

    w5300_bus_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
        .req_wr_data(req_wr_data), .gnt(gnt), .req_op_state(req_op_state),
        .req_rd_data(req_rd_data), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
        .bus_start(bus_start), .bus_done(bus_done), .bus_rd_data(bus_rd_data),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Transaction model: one record for the access currently in flight.
    int          cyc = 0;
    bit          chk_en = 1'b0;
    bit          rand_en = 1'b0;
    bit          tr_valid;
    bit          tr_ok;
    int          tr_g;
    int          tr_end;
    int          tr_win;
    logic [10:0] tr_addr;
    logic [15:0] tr_wd;
    logic [15:0] tr_rdv;
    logic [15:0] rd_before;
    int          to_cycle;
    int          rr;
    int          next_arb;
    int          done_cyc;
    logic [15:0] done_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        tr_valid  = 1'b0;
        tr_ok     = 1'b0;
        tr_g      = 0;
        tr_end    = 0;
        tr_win    = 0;
        rr        = 0;
        rd_before = '0;
        to_cycle  = BIG;
        next_arb  = 0;
        done_cyc  = -1;
        done_data = '0;
    endtask

    function automatic logic [N-1:0] exp_gnt(input int c);
        logic [N-1:0] one = 1;
        return (tr_valid && c >= tr_g && c <= tr_end) ? (one << tr_win) : '0;
    endfunction

    function automatic logic [N-1:0] exp_op(input int c);
        logic [N-1:0] one = 1;
        return (tr_valid && tr_ok && c == tr_end + 1) ? (one << tr_win) : '0;
    endfunction

    function automatic logic [15:0] exp_rd(input int c);
        return (tr_valid && tr_ok && c >= tr_end + 1) ? tr_rdv : rd_before;
    endfunction

    function automatic bit in_access(input int c);
        return tr_valid && c >= tr_g && c <= tr_end + 1;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt", 32'(gnt), 32'(exp_gnt(cyc)));
            check("bus_start", 32'(bus_start), 32'(tr_valid && cyc == tr_g));
            check("op_state", 32'(req_op_state), 32'(exp_op(cyc)));
            check("bus_addr", 32'(bus_addr), 32'(in_access(cyc) ? tr_addr : DEF_ADDR));
            check("bus_wr_data", 32'(bus_wr_data), 32'(in_access(cyc) ? tr_wd : 16'h0));
            check("timeout_err", 32'(timeout_err), 32'(cyc >= to_cycle));
            if (exp_op(cyc) != '0) check("rd_data", 32'(req_rd_data), 32'(exp_rd(cyc)));
        end
    end

    // d: WAIT cycle (1-based) in which bus_done is returned; 0 = never.
    task automatic tick(input logic [N-1:0] r, input int d, input int rdv);
        int w;
        @(posedge clk);
        #1;
        cyc++;
        if (rand_en) begin
            req_addr    = 33'({$urandom(), $urandom()});
            req_wr_data = 48'({$urandom(), $urandom()});
        end
        req         = r;
        bus_done    = (cyc == done_cyc);
        bus_rd_data = bus_done ? done_data : 16'($urandom());
        if (rand_en && !bus_done && !(tr_valid && cyc > tr_g && cyc <= tr_end))
            bus_done = ($urandom_range(0, 3) == 0);
        if (cyc >= next_arb && r != '0) begin
            w = -1;
            for (int k = 0; k < int'(N); k++)
                if (w < 0 && r[(rr + k) % int'(N)]) w = (rr + k) % int'(N);
            rd_before = exp_rd(cyc);
            tr_valid  = 1'b1;
            tr_g      = cyc + 1;
            tr_win    = w;
            tr_addr   = req_addr[11*w +: 11];
            tr_wd     = req_wr_data[16*w +: 16];
            done_data = (rdv >= 0) ? 16'(rdv) : 16'($urandom());
            tr_rdv    = done_data;
            tr_ok     = (d >= 1 && d <= int'(TO));
            tr_end    = tr_ok ? tr_g + d : tr_g + int'(TO);
            done_cyc  = (d > 0) ? tr_g + d : -1;
            if (!tr_ok && to_cycle > tr_end + 1) to_cycle = tr_end + 1;
            rr        = (w + 1) % int'(N);
            next_arb  = tr_end + 2;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick('0, 0, -1);
    endtask

    task automatic check_reset_values();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_start", 32'(bus_start), 32'h0);
        check("rst_op", 32'(req_op_state), 32'h0);
        check("rst_addr", 32'(bus_addr), 32'(DEF_ADDR));
        check("rst_wd", 32'(bus_wr_data), 32'h0);
        check("rst_rd", 32'(req_rd_data), 32'h0);
        check("rst_to", 32'(timeout_err), 32'h0);
    endtask

    initial begin
        int n;
        int d;
        int x;
        rst_n       = 1'b0;
        req         = '0;
        req_addr    = '0;
        req_wr_data = '0;
        bus_done    = 1'b0;
        bus_rd_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        #2;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Single write from requester 0, done 3 cycles after bus_start.
        req_addr[10:0]    = {WR, 10'h200};
        req_wr_data[15:0] = 16'h0b00;
        tick(3'b001, 3, -1);
        tick('0, 0, -1);
        check("wr_gnt", 32'(gnt), 32'h1);
        check("wr_start", 32'(bus_start), 32'h1);
        check("wr_addr", 32'(bus_addr), 32'h600);
        check("wr_data", 32'(bus_wr_data), 32'h0b00);
        idle(3);
        check("wr_no_op_yet", 32'(req_op_state), 32'h0);
        tick('0, 0, -1);
        check("wr_op", 32'(req_op_state), 32'h1);
        idle(2);

        // Read from requester 2 returning 0x0013.
        req_addr[32:22] = {RD, 10'h208};
        tick(3'b100, 2, 16'h0013);
        idle(3);
        tick('0, 0, -1);
        check("rd_op", 32'(req_op_state), 32'h4);
        check("rd_data_lit", 32'(req_rd_data), 32'h0013);
        idle(2);

        // Round robin with all requesters held and done one cycle after start.
        n = 0;
        for (int k = 0; k < 25; k++) begin
            tick((k <= 20) ? 3'b111 : 3'b000, 1, -1);
            if (bus_start) begin
                check("rr_order", 32'(gnt), 32'(3'b001 << (n % 3)));
                n++;
            end
        end
        check("rr_grants", 32'(n), 32'd6);

        // Timeout on requester 0, then requester 1 completes exactly at count 8.
        for (int k = 0; k < 22; k++) begin
            tick(3'b011, (k < 11) ? 0 : 8, -1);
            if (k == 9)  check("to_not_yet", 32'(timeout_err), 32'h0);
            if (k == 10) check("to_set", 32'(timeout_err), 32'h1);
            if (k == 10) check("to_no_op", 32'(req_op_state), 32'h0);
            if (k == 12) check("to_next_gnt", 32'(gnt), 32'h2);
            if (k == 21) check("to_edge_ok", 32'(req_op_state), 32'h2);
        end
        idle(2);

        // Reset while requester 1 is in its WAIT phase.
        tick(3'b010, 0, -1);
        tick('0, 0, -1);
        tick('0, 0, -1);
        check("pre_rst_gnt", 32'(gnt), 32'h2);
        #2;
        rst_n    = 1'b0;
        chk_en   = 1'b0;
        bus_done = 1'b0;
        req      = '0;
        model_reset();
        #1;
        check_reset_values();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick(3'b011, 2, -1);
        tick(3'b011, 2, -1);
        check("post_rst_gnt", 32'(gnt), 32'h1);
        idle(4);

        // Randomized traffic including late and stray bus_done pulses.
        rand_en = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            x = int'($urandom_range(0, 11));
            if (x < 8)       d = x + 1;
            else if (x == 8) d = int'(TO);
            else if (x == 9) d = 0;
            else             d = int'(TO) + x - 9;
            tick(($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(1, 7)), d, -1);
        end
        rand_en = 1'b0;
        idle(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
